// File: rtl/plane_t_stage_if.sv
// Request, divider and result handshake bundle for the ray/plane t stage.
// Latency: none (wires only).
// Backpressure: valid/ready on request and result; divider is launch/strobe.
interface plane_t_stage_if #(
    parameter int D_WIDTH = 32
);
    // request side
    logic                      valid_in;
    logic                      ready_out;
    logic signed [D_WIDTH-1:0] ray_o_x, ray_o_y, ray_o_z;
    logic signed [D_WIDTH-1:0] ray_d_x, ray_d_y, ray_d_z;
    logic signed [D_WIDTH-1:0] pl_p_x, pl_p_y, pl_p_z;
    logic signed [D_WIDTH-1:0] pl_n_x, pl_n_y, pl_n_z;

    // divider side
    logic                      div_valid;
    logic signed [D_WIDTH-1:0] div_dividend;
    logic signed [D_WIDTH-1:0] div_divisor;
    logic                      div_done;
    logic signed [D_WIDTH-1:0] div_quotient;

    // result side
    logic                      valid_out;
    logic                      ready_in;
    logic signed [D_WIDTH-1:0] t;
    logic                      hit;
    logic                      err;

    // stage view
    modport slave (
        input  valid_in,
        output ready_out,
        input  ray_o_x, ray_o_y, ray_o_z,
        input  ray_d_x, ray_d_y, ray_d_z,
        input  pl_p_x, pl_p_y, pl_p_z,
        input  pl_n_x, pl_n_y, pl_n_z,
        output div_valid, div_dividend, div_divisor,
        input  div_done, div_quotient,
        output valid_out,
        input  ready_in,
        output t, hit, err
    );

    // environment view (request source, divider, result sink)
    modport master (
        output valid_in,
        input  ready_out,
        output ray_o_x, ray_o_y, ray_o_z,
        output ray_d_x, ray_d_y, ray_d_z,
        output pl_p_x, pl_p_y, pl_p_z,
        output pl_n_x, pl_n_y, pl_n_z,
        input  div_valid, div_dividend, div_divisor,
        output div_done, div_quotient,
        input  valid_out,
        output ready_in,
        input  t, hit, err
    );
endinterface

// File: rtl/plane_t_stage.sv
// Ray/plane intersection parameter: num = n.(p-o), den = n.d on one multiplier, then t = num/den via external divider.
// Latency: 7 cycles to OUT on parallel rays; 8 + divider response cycles otherwise (WAIT capped at TIMEOUT).
// Backpressure: ready_out only in IDLE; result held on valid_out until ready_in, one request in flight.
module plane_t_stage #(
    parameter int Q_BITS  = 10,
    parameter int D_WIDTH = 32,
    parameter int EPS     = 1,
    parameter int TIMEOUT = 255
) (
    input  logic           clk_i,
    input  logic           rst_i,
    plane_t_stage_if.slave bus
);
    localparam int DIFF_W = D_WIDTH + 1;
    localparam int PROD_W = 2 * D_WIDTH + 1;
    localparam int ACC_W  = 2 * D_WIDTH + 3;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    // Saturation bounds of the signed D_WIDTH range, expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-D_WIDTH+1){1'b0}}, {(D_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NUM,
        S_DEN,
        S_ISSUE,
        S_WAIT,
        S_OUT
    } state_t;

    // latched request operands, index 0/1/2 = x/y/z
    logic signed [D_WIDTH-1:0] o_q [3];
    logic signed [D_WIDTH-1:0] d_q [3];
    logic signed [D_WIDTH-1:0] p_q [3];
    logic signed [D_WIDTH-1:0] n_q [3];

    state_t                    state_q;
    logic [1:0]                k_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]          cnt_q;
    logic signed [D_WIDTH-1:0] num_q;
    logic signed [D_WIDTH-1:0] den_q;
    logic signed [D_WIDTH-1:0] t_q;
    logic                      div_valid_q;
    logic                      valid_out_q;
    logic                      hit_q;
    logic                      err_q;

    // datapath next-state values
    logic signed [D_WIDTH-1:0] sel_o_d, sel_d_d, sel_p_d, sel_n_d;
    logic signed [DIFF_W-1:0]  diff_d;
    logic signed [DIFF_W-1:0]  op_a_d;
    logic signed [PROD_W-1:0]  a_ext_d, b_ext_d, prod_d;
    logic signed [ACC_W-1:0]   acc_d;
    logic signed [ACC_W-1:0]   shifted_d;
    logic signed [D_WIDTH-1:0] scaled_d;
    logic signed [DIFF_W-1:0]  den_ext_d;
    logic [DIFF_W-1:0]         den_abs_d;
    logic                      parallel_d;

    // Shared multiply-accumulate: NUM feeds (p-o), DEN feeds d; both against n of the current component.
    always_comb begin
        sel_o_d = o_q[2];
        sel_d_d = d_q[2];
        sel_p_d = p_q[2];
        sel_n_d = n_q[2];
        case (k_q)
            2'd0: begin
                sel_o_d = o_q[0];
                sel_d_d = d_q[0];
                sel_p_d = p_q[0];
                sel_n_d = n_q[0];
            end
            2'd1: begin
                sel_o_d = o_q[1];
                sel_d_d = d_q[1];
                sel_p_d = p_q[1];
                sel_n_d = n_q[1];
            end
            default: ;
        endcase

        // one extra bit so p - o never wraps
        diff_d  = DIFF_W'(sel_p_d) - DIFF_W'(sel_o_d);
        op_a_d  = (state_q == S_NUM) ? diff_d : DIFF_W'(sel_d_d);
        a_ext_d = PROD_W'(op_a_d);
        b_ext_d = PROD_W'(sel_n_d);
        prod_d  = a_ext_d * b_ext_d;
        acc_d   = acc_q + ACC_W'(prod_d);

        // drop the extra Q fraction of the product, then clamp to D_WIDTH
        shifted_d = acc_d >>> Q_BITS;
        if (shifted_d > SAT_MAX) begin
            scaled_d = {1'b0, {(D_WIDTH-1){1'b1}}};
        end else if (shifted_d < SAT_MIN) begin
            scaled_d = {1'b1, {(D_WIDTH-1){1'b0}}};
        end else begin
            scaled_d = shifted_d[D_WIDTH-1:0];
        end

        // |den| taken one bit wider so the most negative value has a magnitude
        den_ext_d  = DIFF_W'(scaled_d);
        den_abs_d  = (den_ext_d < 0) ? -den_ext_d : den_ext_d;
        parallel_d = (den_abs_d < DIFF_W'(EPS));
    end

    // Control FSM with registered outputs; reset returns to IDLE with all outputs cleared.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            k_q         <= 2'd0;
            acc_q       <= '0;
            cnt_q       <= '0;
            num_q       <= '0;
            den_q       <= '0;
            t_q         <= '0;
            div_valid_q <= 1'b0;
            valid_out_q <= 1'b0;
            hit_q       <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                o_q[i] <= '0;
                d_q[i] <= '0;
                p_q[i] <= '0;
                n_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.valid_in) begin
                        o_q[0]  <= bus.ray_o_x;
                        o_q[1]  <= bus.ray_o_y;
                        o_q[2]  <= bus.ray_o_z;
                        d_q[0]  <= bus.ray_d_x;
                        d_q[1]  <= bus.ray_d_y;
                        d_q[2]  <= bus.ray_d_z;
                        p_q[0]  <= bus.pl_p_x;
                        p_q[1]  <= bus.pl_p_y;
                        p_q[2]  <= bus.pl_p_z;
                        n_q[0]  <= bus.pl_n_x;
                        n_q[1]  <= bus.pl_n_y;
                        n_q[2]  <= bus.pl_n_z;
                        acc_q   <= '0;
                        k_q     <= 2'd0;
                        state_q <= S_NUM;
                    end
                end
                S_NUM: begin
                    if (k_q == 2'd2) begin
                        num_q   <= scaled_d;
                        acc_q   <= '0;
                        k_q     <= 2'd0;
                        state_q <= S_DEN;
                    end else begin
                        acc_q <= acc_d;
                        k_q   <= k_q + 2'd1;
                    end
                end
                S_DEN: begin
                    if (k_q == 2'd2) begin
                        den_q <= scaled_d;
                        acc_q <= '0;
                        k_q   <= 2'd0;
                        if (parallel_d) begin
                            // no meaningful quotient exists; answer without the divider
                            t_q         <= '0;
                            hit_q       <= 1'b0;
                            err_q       <= 1'b0;
                            valid_out_q <= 1'b1;
                            state_q     <= S_OUT;
                        end else begin
                            div_valid_q <= 1'b1;
                            state_q     <= S_ISSUE;
                        end
                    end else begin
                        acc_q <= acc_d;
                        k_q   <= k_q + 2'd1;
                    end
                end
                S_ISSUE: begin
                    div_valid_q <= 1'b0;
                    cnt_q       <= '0;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    // a strobe on the final counted cycle still wins over the timeout
                    if (bus.div_done) begin
                        t_q         <= bus.div_quotient;
                        hit_q       <= (bus.div_quotient > 0);
                        err_q       <= 1'b0;
                        valid_out_q <= 1'b1;
                        state_q     <= S_OUT;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        t_q         <= '0;
                        hit_q       <= 1'b0;
                        err_q       <= 1'b1;
                        valid_out_q <= 1'b1;
                        state_q     <= S_OUT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_OUT: begin
                    if (bus.ready_in) begin
                        valid_out_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ready is withheld while reset is applied even though the state already reads IDLE
    assign bus.ready_out    = (state_q == S_IDLE) && !rst_i;
    assign bus.div_valid    = div_valid_q;
    assign bus.div_dividend = num_q;
    assign bus.div_divisor  = den_q;
    assign bus.valid_out    = valid_out_q;
    assign bus.t            = t_q;
    assign bus.hit          = hit_q;
    assign bus.err          = err_q;

endmodule

// File: tb/tb_plane_t_stage.sv
// Directed bench for plane_t_stage with an inline divider stub and result sink.
// Cycle numbers count from the accepting edge (edge 0); outputs are sampled on the falling edge.
// TIMEOUT is shortened to 16 so the abandon path is reached quickly.
module tb_plane_t_stage;
    logic clk;
    logic rst;

    plane_t_stage_if #(.D_WIDTH(32)) bus ();

    plane_t_stage #(
        .Q_BITS (10),
        .D_WIDTH(32),
        .EPS    (1),
        .TIMEOUT(16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // observations from the last request
    int                 issue_cyc;
    int                 n_div;
    int                 vo_cyc;
    bit                 hold_ok;
    bit                 consumed;
    logic signed [31:0] cap_t, cap_dvd, cap_dvs;
    logic               cap_hit, cap_err;

    task automatic check_val(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_vec(input logic signed [31:0] ox, oy, oz, dx, dy, dz,
                           input logic signed [31:0] px, py, pz, nx, ny, nz);
        bus.ray_o_x = ox; bus.ray_o_y = oy; bus.ray_o_z = oz;
        bus.ray_d_x = dx; bus.ray_d_y = dy; bus.ray_d_z = dz;
        bus.pl_p_x  = px; bus.pl_p_y  = py; bus.pl_p_z  = pz;
        bus.pl_n_x  = nx; bus.pl_n_y  = ny; bus.pl_n_z  = nz;
    endtask

    // Issue the staged request, play divider (done_dly cycles after the launch, -1 = never)
    // and sink (ready_in low for hold_lo cycles of valid_out). late_done keeps div_done
    // asserted while the result waits. Returns at the falling edge after the consuming edge.
    task automatic run_req(input int done_dly, input logic signed [31:0] quot, input int hold_lo,
                           input bit late_done, input logic signed [31:0] exp_t,
                           input logic exp_hit, input logic exp_err);
        int cyc;
        issue_cyc = -1; n_div = 0; vo_cyc = -1; hold_ok = 1; consumed = 0;
        cap_t = 'x; cap_dvd = 'x; cap_dvs = 'x; cap_hit = 'x; cap_err = 'x;
        bus.valid_in = 1'b1;
        @(posedge clk);
        #1 bus.valid_in = 1'b0;
        cyc = 1;
        while (!consumed && cyc < 400) begin
            @(negedge clk);
            if (bus.ready_out !== 1'b0) hold_ok = 0;
            if (bus.div_valid === 1'b1) begin
                n_div++;
                if (issue_cyc < 0) issue_cyc = cyc;
            end
            if (bus.valid_out === 1'b1) begin
                if (vo_cyc < 0) begin
                    vo_cyc  = cyc;
                    cap_t   = bus.t;
                    cap_hit = bus.hit;
                    cap_err = bus.err;
                    cap_dvd = bus.div_dividend;
                    cap_dvs = bus.div_divisor;
                end
                if (bus.t !== exp_t || bus.hit !== exp_hit || bus.err !== exp_err) hold_ok = 0;
            end else if (vo_cyc >= 0) begin
                hold_ok = 0;
            end
            bus.div_done = (issue_cyc >= 0 && done_dly >= 0 && cyc == issue_cyc + done_dly) ||
                           (late_done && vo_cyc >= 0);
            bus.div_quotient = bus.div_done ? quot : 32'sd0;
            bus.ready_in = (vo_cyc >= 0 && cyc >= vo_cyc + hold_lo);
            if (bus.ready_in) begin
                @(posedge clk);
                consumed = 1;
            end
            cyc++;
        end
        @(negedge clk);
        bus.ready_in     = 1'b0;
        bus.div_done     = 1'b0;
        bus.div_quotient = '0;
    endtask

    task automatic check_txn(input string nm, input int e_issue, input int e_ndiv, input int e_vo,
                             input logic signed [31:0] e_dvd, input logic signed [31:0] e_dvs,
                             input logic signed [31:0] e_t, input logic e_hit, input logic e_err);
        check_val({nm, ".consumed"}, consumed, 1);
        check_val({nm, ".issue_cyc"}, issue_cyc, e_issue);
        check_val({nm, ".div_pulses"}, n_div, e_ndiv);
        check_val({nm, ".valid_out_cyc"}, vo_cyc, e_vo);
        check_val({nm, ".dividend"}, cap_dvd, e_dvd);
        check_val({nm, ".divisor"}, cap_dvs, e_dvs);
        check_val({nm, ".t"}, cap_t, e_t);
        check_val({nm, ".hit"}, cap_hit, e_hit);
        check_val({nm, ".err"}, cap_err, e_err);
        check_val({nm, ".held_stable"}, hold_ok, 1);
        check_val({nm, ".ready_after"}, bus.ready_out, 1);
        check_val({nm, ".valid_after"}, bus.valid_out, 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clk = 1'b0;
        rst = 1'b1;
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b0;
        bus.div_done = 1'b0;
        bus.div_quotient = '0;
        set_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst.ready_out", bus.ready_out, 0);
        check_val("rst.valid_out", bus.valid_out, 0);
        check_val("rst.div_valid", bus.div_valid, 0);
        check_val("rst.t", bus.t, 0);
        check_val("rst.hit_err", {bus.hit, bus.err}, 0);
        check_val("rst.dividend", bus.div_dividend, 0);
        check_val("rst.divisor", bus.div_divisor, 0);
        rst = 1'b0;
        @(negedge clk);
        check_val("idle.ready_out", bus.ready_out, 1);

        // hit along +z: num = 1024*5120>>10 = 5120, den = 1024*1024>>10 = 1024
        set_vec(0, 0, 0, 0, 0, 1024, 0, 0, 5120, 0, 0, 1024);
        run_req(3, 5120, 0, 0, 5120, 1, 0);
        check_txn("hit_z", 7, 1, 11, 5120, 1024, 5120, 1, 0);

        // parallel: den = 0, no divide, result at cycle 7
        set_vec(0, 0, 0, 1024, 0, 0, 0, 0, 5120, 0, 0, 1024);
        run_req(3, 0, 0, 0, 0, 0, 0);
        check_txn("parallel", -1, 0, 7, 5120, 0, 0, 0, 0);

        // plane behind the origin: num = -5120
        set_vec(0, 0, 0, 0, 0, 1024, 0, 0, -5120, 0, 0, 1024);
        run_req(3, -5120, 0, 0, -5120, 0, 0);
        check_txn("behind", 7, 1, 11, -5120, 1024, -5120, 0, 0);

        // all three components: diffs (1024,1024,-1000), n=(2048,-1024,512), d=(512,1024,-2048)
        // num = (2097152 - 1048576 - 512000)>>10 = 524, den = (1048576 - 1048576 - 1048576)>>10 = -1024
        set_vec(100, 200, 300, 512, 1024, -2048, 1124, 1224, -700, 2048, -1024, 512);
        run_req(2, -524, 0, 0, -524, 0, 0);
        check_txn("mixed", 7, 1, 10, 524, -1024, -524, 0, 0);

        // backpressure: ready_in low for 4 cycles of valid_out; next request goes straight in
        set_vec(0, 0, 0, 0, 0, 1024, 0, 0, 5120, 0, 0, 1024);
        run_req(3, 5120, 4, 0, 5120, 1, 0);
        check_txn("backpressure", 7, 1, 11, 5120, 1024, 5120, 1, 0);

        // timeout: no strobe, 16 WAIT cycles (8..23), result at 24; late strobe while held is ignored
        run_req(-1, 999, 3, 1, 0, 0, 1);
        check_txn("timeout", 7, 1, 24, 5120, 1024, 0, 0, 1);

        // reset in WAIT, then a stray strobe, then a fresh request
        bus.valid_in = 1'b1;
        @(posedge clk);
        #1 bus.valid_in = 1'b0;
        repeat (9) @(negedge clk);
        check_val("rst_mid.pre_dividend", bus.div_dividend, 5120);
        check_val("rst_mid.pre_ready", bus.ready_out, 0);
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_mid.ready_out", bus.ready_out, 0);
        check_val("rst_mid.dividend", bus.div_dividend, 0);
        check_val("rst_mid.divisor", bus.div_divisor, 0);
        check_val("rst_mid.flags", {bus.valid_out, bus.div_valid, bus.hit, bus.err}, 0);
        rst = 1'b0;
        bus.div_done = 1'b1;
        bus.div_quotient = 777;
        @(negedge clk);
        bus.div_done = 1'b0;
        bus.div_quotient = '0;
        check_val("rst_mid.stray_done_valid", bus.valid_out, 0);
        check_val("rst_mid.stray_done_t", bus.t, 0);
        check_val("rst_mid.ready_out_after", bus.ready_out, 1);
        run_req(1, 5120, 0, 0, 5120, 1, 0);
        check_txn("after_rst", 7, 1, 9, 5120, 1024, 5120, 1, 0);

        // saturation: n.x = 2^31-1, p.x - o.x = 2^30 -> num clamps to 2^31-1;
        // den = (2^31-1)*1024>>10 = 2^31-1 exactly
        set_vec(0, 0, 0, 1024, 0, 0, 32'sh4000_0000, 0, 0, 32'sh7FFF_FFFF, 0, 0);
        run_req(1, 1024, 0, 0, 1024, 1, 0);
        check_txn("saturate", 7, 1, 9, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 1024, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/plane_t_stage.md
# plane_t_stage

Ray/plane intersection-parameter stage, directly upstream of the fixed-point divider in the ray tracer pipeline. It accepts one ray (origin, direction) and one plane (point, normal) and forms numerator = n·(p − o) and denominator = n·d with a single shared multiplier. It then launches one divide request and returns t = num/den with a hit flag. Parallel rays and divider timeouts are resolved here without a divide.

## Interface
- Q_BITS, 10: fractional bits of every fixed-point operand and result.
- D_WIDTH, 32: signed data width of all vector components, num, den and t.
- EPS, 1: parallel threshold; a ray is treated as parallel when |den| < EPS (raw LSBs).
- TIMEOUT, 255: maximum cycles spent in WAIT before the request is abandoned.
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clock.
- valid_in  in  1  request valid.
- ready_out  out  1  high only in IDLE; a transfer occurs when valid_in && ready_out.
- ray_o_x/y/z, ray_d_x/y/z, pl_p_x/y/z, pl_n_x/y/z  in  D_WIDTH each, signed  ray origin, ray direction, plane point, plane normal.
- div_valid  out  1  one-cycle divide launch pulse.
- div_dividend, div_divisor  out  D_WIDTH signed  num and den; held stable from ISSUE until the divide completes or times out.
- div_done  in  1  divider result strobe, sampled only in WAIT.
- div_quotient  in  D_WIDTH signed  divider result, valid when div_done is high.
- valid_out  out  1  result valid; held until ready_in.
- ready_in  in  1  downstream accept.
- t  out  D_WIDTH signed  intersection parameter.
- hit  out  1  1 when the ray is not parallel, t > 0 and err = 0.
- err  out  1  1 when the divider timed out.

## Operation
- FSM states:
  - IDLE: latch all 12 inputs on transfer, clear the accumulator, go to NUM.
  - NUM: 3 cycles, component k = x,y,z; acc += n_k*(p_k − o_k).
  - DEN: 3 cycles; acc += n_k*d_k.
  - ISSUE: assert div_valid, go to WAIT.
  - WAIT: count cycles; on div_done, go to OUT.
  - OUT: hold outputs until ready_in.
- Arithmetic widths:
  - Differences p_k − o_k are computed in D_WIDTH+1 bits.
  - Products are 2*D_WIDTH+1 bits; the accumulator is 2*D_WIDTH+3 bits.
- End-of-phase scaling: at the end of NUM and of DEN, acc is arithmetic-shifted right by Q_BITS and saturated to the signed D_WIDTH range. The results are stored as num and den.
- Parallel path: at the end of DEN, if |den| < EPS, skip ISSUE/WAIT and go straight to OUT with t=0, hit=0, err=0.
- Divide path: on div_done in WAIT, set t = div_quotient, hit = (t > 0), err = 0.
- Timeout: the WAIT counter starts at 0 on entry. If it reaches TIMEOUT with no div_done, go to OUT with t=0, hit=0, err=1; a later div_done is ignored.
- On valid_out && ready_in: go to IDLE.
- Simultaneous events:
  - OUT never overlaps IDLE, so the next request is accepted one cycle after the output is consumed.
  - div_done arriving in the same cycle the counter reaches TIMEOUT counts as success.

## Timing
- Cycle numbering: accept is at edge 0; NUM occupies cycles 1–3; DEN occupies cycles 4–6.
- Divide path:
  - Cycle 7 is ISSUE, with div_valid high for exactly that cycle.
  - WAIT runs from cycle 8.
  - If div_done is sampled at cycle W, valid_out rises at cycle W+1.
- Parallel path: valid_out rises at cycle 7, and div_valid is never asserted.
- Minimum throughput: one request per 10 cycles, assuming a 1-cycle divider response and ready_in held high.
- Reset values: ready_out=0 while reset is high, then 1 in IDLE; div_valid=0, valid_out=0, t=0, hit=0, err=0; div_dividend and div_divisor = 0.
- Reset asserted mid-operation (any state) forces IDLE and zeroes all outputs on the next edge. A div_done arriving after reset is ignored.

## Test plan
- Hit along +z: Q_BITS=10, o=(0,0,0), d=(0,0,1024), p=(0,0,5120), n=(0,0,1024); divider stub returns 5120 after 3 cycles. Expected: div_dividend=5120, div_divisor=1024, one div_valid pulse at cycle 7, valid_out at cycle 11, t=5120, hit=1, err=0.
- Parallel: d=(1024,0,0), other inputs as above. Expected: den=0, no div_valid, valid_out at cycle 7, t=0, hit=0.
- Behind the ray: p=(0,0,−5120); stub returns −5120. Expected: num=−5120, t=−5120, hit=0, err=0.
- Backpressure: ready_in held low for 4 cycles after valid_out. Expected: t/hit/err stable, ready_out=0 throughout; a new valid_in is accepted one cycle after the consuming edge.
- Timeout: TIMEOUT=16, stub never asserts div_done. Expected: valid_out after 16 WAIT cycles with err=1, hit=0, t=0; a late div_done is ignored.
- Reset mid-WAIT, then saturation:
  - Assert reset during WAIT. Expected: next cycle all outputs are 0 and state is IDLE; a fresh request then completes normally.
  - Drive n=(2^31−1,0,0), p−o=(2^30,0,0). Expected: num saturates to 2^31−1.
